// File: rtl/issue_queue.sv
// issue_queue: dual-issue instruction queue between decode and the issue/EXE register.
// Decode pushes up to two entries per cycle. The two oldest entries are presented as
// slot 1 (older) and slot 2 (younger).
// Build macro ISSUE_Q_DUAL_ISSUE_EN:
//   defined   -> pair checking is active and up to two entries pop per cycle.
//   undefined -> slot 2 never issues and at most one entry pops per cycle.
module issue_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRY_W = 256
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   in_valid_1,
  input  logic                   in_valid_2,
  input  logic [ENTRY_W-1:0]     in_data_1,
  input  logic [ENTRY_W-1:0]     in_data_2,
  input  logic [4:0]             in_rd_1,
  input  logic [4:0]             in_rd_2,
  input  logic                   in_we_1,
  input  logic                   in_we_2,
  input  logic [4:0]             in_rs1_1,
  input  logic [4:0]             in_rs2_1,
  input  logic [4:0]             in_rs1_2,
  input  logic [4:0]             in_rs2_2,
  input  logic [9:0]             in_type_1,
  input  logic [9:0]             in_type_2,
  output logic                   in_ready,
  output logic                   out_valid_1,
  output logic                   out_valid_2,
  output logic [ENTRY_W-1:0]     out_data_1,
  output logic [ENTRY_W-1:0]     out_data_2,
  output logic [4:0]             out_rs1_1,
  output logic [4:0]             out_rs2_1,
  output logic [4:0]             out_rs1_2,
  output logic [4:0]             out_rs2_2,
  output logic [9:0]             out_type_1,
  output logic [9:0]             out_type_2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 10;

  typedef struct packed {
    logic [ENTRY_W-1:0] data;
    logic [REG_W-1:0]   rd;
    logic               we;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [TYPE_W-1:0]  itype;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  entry_t           in_e1;
  entry_t           in_e2;
  entry_t           slot1;
  entry_t           slot2;
  logic             push_en;
  logic             pop_en;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_pop;

  assign in_e1   = {in_data_1, in_rd_1, in_we_1, in_rs1_1, in_rs2_1, in_type_1};
  assign in_e2   = {in_data_2, in_rd_2, in_we_2, in_rs1_2, in_rs2_2, in_type_2};
  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Slots read straight from storage; there is no push-to-output bypass.
  assign slot1 = mem[head];
  assign slot2 = mem[head_p1];

  // Readiness uses the registered count only; a same-cycle pop does not help.
  assign in_ready    = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign out_valid_1 = (count != '0) & ~flush;

`ifdef ISSUE_Q_DUAL_ISSUE_EN
  logic raw_hazard;
  logic waw_hazard;
  logic has_alu;
  logic pair_ok;

  // Slot 2 issues alongside slot 1 only if independent and one of them is plain ALU.
  assign raw_hazard = slot1.we & (slot1.rd != '0) &
                      ((slot2.rs1 == slot1.rd) | (slot2.rs2 == slot1.rd));
  assign waw_hazard = slot1.we & slot2.we & (slot1.rd != '0) & (slot1.rd == slot2.rd);
  assign has_alu    = (slot1.itype == TYPE_W'(1)) | (slot2.itype == TYPE_W'(1));
  assign pair_ok    = ~raw_hazard & ~waw_hazard & has_alu;
  assign out_valid_2 = (count >= CNT_W'(2)) & pair_ok & ~flush;
`else
  logic unused_pair_fields;

  // Single issue: hazard fields are stored but never consulted.
  assign unused_pair_fields = ^{slot1.rd, slot1.we, slot2.rd, slot2.we};
  assign out_valid_2 = 1'b0;
`endif

  assign out_data_1 = slot1.data;
  assign out_rs1_1  = slot1.rs1;
  assign out_rs2_1  = slot1.rs2;
  assign out_type_1 = slot1.itype;
  assign out_data_2 = slot2.data;
  assign out_rs1_2  = slot2.rs1;
  assign out_rs2_2  = slot2.rs2;
  assign out_type_2 = slot2.itype;

  // Push and pop amounts for this cycle; flush suppresses both.
  assign push_en = in_ready & ~flush;
  assign pop_en  = ~stall & ~flush;
  assign n_push  = push_en ? (CNT_W'(in_valid_1) + CNT_W'(in_valid_2)) : '0;
  assign n_pop   = pop_en ? (CNT_W'(out_valid_1) + CNT_W'(out_valid_2)) : '0;

  // Pointer and occupancy update; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - n_pop;
    end
  end

  // Compacting write: the first valid input always lands at tail.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (in_valid_1) begin
        mem[tail] <= in_e1;
        if (in_valid_2) begin
          mem[tail_p1] <= in_e2;
        end
      end else if (in_valid_2) begin
        mem[tail] <= in_e2;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed table, hand-written corner sequences and randomized traffic
// checked against a queue-based reference model of issue_queue.
module tb_issue_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned EW    = 256;
  localparam logic [9:0]  ALU   = 10'h001;
  localparam logic [9:0]  MUL   = 10'h004;
  localparam logic [9:0]  DIV   = 10'h008;
`ifdef ISSUE_Q_DUAL_ISSUE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  typedef struct packed {
    logic [EW-1:0] data;
    logic [4:0]    rd;
    logic          we;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [9:0]    ty;
  } ent_t;

  typedef struct {
    ent_t a;
    ent_t b;
    bit   pair;
  } vec_t;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          stall;
  logic          in_valid_1, in_valid_2;
  logic [EW-1:0] in_data_1, in_data_2;
  logic [4:0]    in_rd_1, in_rd_2;
  logic          in_we_1, in_we_2;
  logic [4:0]    in_rs1_1, in_rs2_1, in_rs1_2, in_rs2_2;
  logic [9:0]    in_type_1, in_type_2;
  logic          in_ready;
  logic          out_valid_1, out_valid_2;
  logic [EW-1:0] out_data_1, out_data_2;
  logic [4:0]    out_rs1_1, out_rs2_1, out_rs1_2, out_rs2_2;
  logic [9:0]    out_type_1, out_type_2;
  logic [3:0]    count;

  issue_queue #(.DEPTH(DEPTH), .ENTRY_W(EW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_rd_1(in_rd_1), .in_rd_2(in_rd_2), .in_we_1(in_we_1), .in_we_2(in_we_2),
    .in_rs1_1(in_rs1_1), .in_rs2_1(in_rs2_1), .in_rs1_2(in_rs1_2), .in_rs2_2(in_rs2_2),
    .in_type_1(in_type_1), .in_type_2(in_type_2), .in_ready(in_ready),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_rs1_1(out_rs1_1), .out_rs2_1(out_rs2_1), .out_rs1_2(out_rs1_2), .out_rs2_2(out_rs2_2),
    .out_type_1(out_type_1), .out_type_2(out_type_2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue contents in age order, oldest first.
  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_npop = 0;
  bit   exp_rdy  = 1'b1;
  ent_t cur_a, cur_b;
  int   uid = 100;

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic bit pair_ok_m(input ent_t x, input ent_t y);
    bit raw, waw, alu;
    raw = x.we && (x.rd != 5'd0) && ((y.rs1 == x.rd) || (y.rs2 == x.rd));
    waw = x.we && y.we && (x.rd != 5'd0) && (x.rd == y.rd);
    alu = (x.ty == ALU) || (y.ty == ALU);
    return !raw && !waw && alu;
  endfunction

  function automatic ent_t mk(input int id, input logic [4:0] rd, input bit we,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [9:0] ty);
    ent_t e;
    e.data = {8{32'(id) ^ 32'h5A5A_0000}};
    e.rd = rd; e.we = we; e.rs1 = rs1; e.rs2 = rs2; e.ty = ty;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    for (int i = 0; i < 8; i++) e.data[i*32 +: 32] = $urandom;
    e.rd  = 5'($urandom_range(0, 7));
    e.we  = 1'($urandom_range(0, 1));
    e.rs1 = 5'($urandom_range(0, 7));
    e.rs2 = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 0) e.ty = ALU;
    else e.ty = 10'(10'h001 << $urandom_range(1, 9));
    return e;
  endfunction

  function automatic ent_t nxt_alu();
    uid++;
    return mk(uid, 5'(uid % 31 + 1), 1'b1, 5'd0, 5'd0, ALU);
  endfunction

  // Drive one cycle's inputs at the falling edge and compare outputs with the model.
  task automatic drive_check(input bit fl, input bit st, input bit v1, input bit v2,
                             input ent_t a, input ent_t b);
    bit e_ov1, e_ov2;
    @(negedge clk);
    rstn = 1'b1; flush = fl; stall = st; in_valid_1 = v1; in_valid_2 = v2;
    in_data_1 = a.data; in_rd_1 = a.rd; in_we_1 = a.we;
    in_rs1_1 = a.rs1; in_rs2_1 = a.rs2; in_type_1 = a.ty;
    in_data_2 = b.data; in_rd_2 = b.rd; in_we_2 = b.we;
    in_rs1_2 = b.rs1; in_rs2_2 = b.rs2; in_type_2 = b.ty;
    cur_a = a; cur_b = b;
    #1;
    e_ov1 = (q.size() >= 1) && !fl;
    e_ov2 = 1'b0;
    if (DUAL && q.size() >= 2 && !fl) e_ov2 = pair_ok_m(q[0], q[1]);
    exp_rdy = (int'(DEPTH) - q.size()) >= 2;
    chk("m_count", EW'(count), EW'(q.size()));
    chk("m_in_ready", EW'(in_ready), EW'(exp_rdy));
    chk("m_out_valid_1", EW'(out_valid_1), EW'(e_ov1));
    chk("m_out_valid_2", EW'(out_valid_2), EW'(e_ov2));
    if (q.size() >= 1) begin
      chk("m_data_1", out_data_1, q[0].data);
      chk("m_rs_1", EW'({out_rs1_1, out_rs2_1, out_type_1}), EW'({q[0].rs1, q[0].rs2, q[0].ty}));
    end
    if (q.size() >= 2) begin
      chk("m_data_2", out_data_2, q[1].data);
      chk("m_rs_2", EW'({out_rs1_2, out_rs2_2, out_type_2}), EW'({q[1].rs1, q[1].rs2, q[1].ty}));
    end
    exp_npop = st ? 0 : (int'(e_ov1) + int'(e_ov2));
  endtask

  // Advance through the rising edge and apply the same cycle to the model.
  task automatic clock_update();
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      for (int i = 0; i < exp_npop; i++) void'(q.pop_front());
      if (exp_rdy) begin
        if (in_valid_1) q.push_back(cur_a);
        if (in_valid_2) q.push_back(cur_b);
      end
    end
  endtask

  task automatic step(input bit fl, input bit st, input bit v1, input bit v2,
                      input ent_t a, input ent_t b);
    drive_check(fl, st, v1, v2, a, b);
    clock_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; flush = 1'b0; stall = 1'b0; in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    chk("rst_count", EW'(count), EW'(0));
    chk("rst_out_valid_1", EW'(out_valid_1), EW'(0));
    chk("rst_out_valid_2", EW'(out_valid_2), EW'(0));
    chk("rst_in_ready", EW'(in_ready), EW'(1));
  endtask

  // Empty the queue with stall low, returning the number of cycles it took.
  task automatic drain(output int n, output bit saw2);
    ent_t z;
    z = '0; n = 0; saw2 = 1'b0;
    while (q.size() != 0 && n < 20) begin
      drive_check(1'b0, 1'b0, 1'b0, 1'b0, z, z);
      if (out_valid_2) saw2 = 1'b1;
      clock_update();
      n++;
    end
    chk("drain_bound", EW'(q.size()), EW'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[11];
    ent_t z;
    int   n;
    bit   saw2;
    bit   paired;
    z = '0;
    rstn = 1'b0; flush = 1'b0; stall = 1'b0; in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_data_1 = '0; in_data_2 = '0; in_rd_1 = '0; in_rd_2 = '0; in_we_1 = 1'b0; in_we_2 = 1'b0;
    in_rs1_1 = '0; in_rs2_1 = '0; in_rs1_2 = '0; in_rs2_2 = '0; in_type_1 = '0; in_type_2 = '0;

    tbl[0]  = '{mk(1, 3, 1, 1, 2, ALU), mk(2, 4, 1, 1, 2, ALU), 1'b1};  // independent
    tbl[1]  = '{mk(3, 5, 1, 1, 2, ALU), mk(4, 6, 1, 5, 2, ALU), 1'b0};  // RAW on rs1
    tbl[2]  = '{mk(5, 0, 1, 1, 2, ALU), mk(6, 6, 1, 0, 2, ALU), 1'b1};  // rd1 = r0
    tbl[3]  = '{mk(7, 5, 1, 1, 2, ALU), mk(8, 6, 1, 1, 5, ALU), 1'b0};  // RAW on rs2
    tbl[4]  = '{mk(9, 5, 0, 1, 2, ALU), mk(10, 6, 1, 5, 2, ALU), 1'b1}; // no write
    tbl[5]  = '{mk(11, 7, 1, 1, 2, ALU), mk(12, 7, 1, 1, 2, ALU), 1'b0}; // WAW
    tbl[6]  = '{mk(13, 7, 1, 1, 2, ALU), mk(14, 7, 0, 1, 2, ALU), 1'b1}; // we2 low
    tbl[7]  = '{mk(15, 3, 1, 1, 2, DIV), mk(16, 4, 1, 1, 2, MUL), 1'b0}; // no ALU
    tbl[8]  = '{mk(17, 3, 1, 1, 2, DIV), mk(18, 4, 1, 1, 2, ALU), 1'b1}; // div + ALU
    tbl[9]  = '{mk(19, 3, 1, 1, 2, ALU), mk(20, 4, 1, 1, 2, MUL), 1'b1}; // ALU + mul
    tbl[10] = '{mk(21, 3, 1, 4, 2, ALU), mk(22, 4, 1, 1, 2, ALU), 1'b1}; // WAR only

    // Pairing table: push both, then check issue and remaining occupancy.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, tbl[i].a, tbl[i].b);
      drive_check(1'b0, 1'b0, 1'b0, 1'b0, z, z);
      paired = tbl[i].pair & DUAL;
      chk($sformatf("tbl%0d_ov1", i), EW'(out_valid_1), EW'(1));
      chk($sformatf("tbl%0d_ov2", i), EW'(out_valid_2), EW'(paired));
      chk($sformatf("tbl%0d_count", i), EW'(count), EW'(2));
      chk($sformatf("tbl%0d_rs1_2", i), EW'(out_rs1_2), EW'(tbl[i].b.rs1));
      clock_update();
      drive_check(1'b0, 1'b0, 1'b0, 1'b0, z, z);
      chk($sformatf("tbl%0d_count_after", i), EW'(count), EW'(paired ? 0 : 1));
      if (!paired) begin
        chk($sformatf("tbl%0d_second_data", i), out_data_1, tbl[i].b.data);
        chk($sformatf("tbl%0d_second_ov2", i), EW'(out_valid_2), EW'(0));
      end
      clock_update();
    end

    // Only slot 2 valid: it is compacted into the head entry.
    do_reset();
    cur_b = nxt_alu();
    step(1'b0, 1'b1, 1'b0, 1'b1, z, cur_b);
    drive_check(1'b0, 1'b1, 1'b0, 1'b0, z, z);
    chk("v2only_data", out_data_1, q[0].data);
    chk("v2only_count", EW'(count), EW'(1));
    chk("v2only_ov2", EW'(out_valid_2), EW'(0));
    clock_update();

    // Fill with pairs under stall: ready at 6, full at 8.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_check(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
      if (k == 3) begin
        chk("fill_count6", EW'(count), EW'(6));
        chk("fill_ready6", EW'(in_ready), EW'(1));
      end
      clock_update();
    end
    drive_check(1'b0, 1'b1, 1'b0, 1'b0, z, z);
    chk("fill_count8", EW'(count), EW'(8));
    chk("fill_ready8", EW'(in_ready), EW'(0));
    clock_update();
    drain(n, saw2);
    chk("fill_drain_cycles", EW'(n), EW'(DUAL ? 4 : 8));

    // Wrap: advance head to 4, fill to 7 across the end of storage, drain.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    drain(n, saw2);
    step(1'b0, 1'b1, 1'b1, 1'b0, nxt_alu(), z);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    drive_check(1'b0, 1'b1, 1'b0, 1'b0, z, z);
    chk("wrap_count7", EW'(count), EW'(7));
    chk("wrap_ready7", EW'(in_ready), EW'(0));
    clock_update();
    drive_check(1'b0, 1'b0, 1'b0, 1'b0, z, z);
    chk("full_ready_with_pop", EW'(in_ready), EW'(0));
    clock_update();
    drain(n, saw2);
    chk("wrap_drain_cycles", EW'(n + 1), EW'(DUAL ? 4 : 7));

    // Flush during stall with a simultaneous push.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    step(1'b0, 1'b1, 1'b1, 1'b0, nxt_alu(), z);
    drive_check(1'b1, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    chk("flush_cycle_ov1", EW'(out_valid_1), EW'(0));
    chk("flush_cycle_count", EW'(count), EW'(5));
    clock_update();
    drive_check(1'b0, 1'b1, 1'b0, 1'b0, z, z);
    chk("flush_count", EW'(count), EW'(0));
    chk("flush_ov1", EW'(out_valid_1), EW'(0));
    chk("flush_ov2", EW'(out_valid_2), EW'(0));
    chk("flush_ready", EW'(in_ready), EW'(1));
    clock_update();

    // Four independent ALU ops: pop cycles depend on issue width.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    drain(n, saw2);
    chk("four_alu_cycles", EW'(n), EW'(DUAL ? 2 : 4));
    chk("four_alu_saw_ov2", EW'(saw2), EW'(DUAL));

    // Reset in the middle of operation discards contents.
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    step(1'b0, 1'b1, 1'b1, 1'b1, nxt_alu(), nxt_alu());
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0, nxt_alu(), z);
    drive_check(1'b0, 1'b1, 1'b0, 1'b0, z, z);
    chk("post_reset_count", EW'(count), EW'(1));
    clock_update();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      bit fl, st, v1, v2, rdy;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      rdy = (int'(DEPTH) - q.size()) >= 2;
      fl  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      v1  = rdy && ($urandom_range(0, 2) != 0);
      v2  = rdy && ($urandom_range(0, 2) != 0);
      step(fl, st, v1, v2, rnd_ent(), rnd_ent());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
